// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the board clock/key control stage.
// Optional feature macro used by clk_key_ctrl: CLK_STEP_COUNT_EN.
package clk_ctrl_pkg;

  typedef enum logic {
    MODE_AUTO,
    MODE_MANUAL
  } mode_e;

  localparam int SEL_W  = 2;
  localparam int FDIV_W = 8;

  localparam logic             RST_FAST = 1'b1;
  localparam mode_e            RST_MODE = MODE_AUTO;
  localparam logic [SEL_W-1:0] RST_SEL  = '0;

  // A division factor of zero behaves as one.
  function automatic logic [FDIV_W-1:0] fdiv_clamp(input logic [FDIV_W-1:0] f);
    return (f == '0) ? FDIV_W'(1) : f;
  endfunction

endpackage

// File: rtl/clk_key_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the released->pressed debounced transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             db_q;
  logic             armed_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronizer resets to "pressed" and the pulse stays disarmed until a
  // real released level is seen, so a key held through reset cannot pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= ~key_ni;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (!sync_q) armed_q <= 1'b1;
      if (sync_q != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q    <= sync_q;
          cnt_q   <= '0;
          press_q <= sync_q & armed_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pressed_o = db_q;
  assign press_o   = press_q;

endmodule

// File: rtl/clk_key_ctrl.sv
// CPU clock generator (fast/slow divider or manual KEY3) with key-driven mode
// and display-window select. CLK_STEP_COUNT_EN adds the manual step counter.
module clk_key_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SLOW_SHIFT      = 20
) (
  input  logic              CLOCK_50,
  input  logic              iRST,
  input  logic [2:0]        iKEY,
  input  logic [FDIV_W-1:0] iFdiv,
  output logic              oCLK,
  output logic              oCLKSelectFast,
  output logic              oCLKSelectAuto,
  output logic [SEL_W-1:0]  oSelect
`ifdef CLK_STEP_COUNT_EN
  ,
  output logic [15:0]       oStepCount
`endif
);

  localparam int unsigned CNT_W = FDIV_W + SLOW_SHIFT;

  logic p1, p2, k3_level;
  logic unused_lvl1, unused_lvl2, unused_p3;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk_i(CLOCK_50), .rst_i(iRST), .key_ni(iKEY[0]),
    .pressed_o(unused_lvl1), .press_o(p1)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk_i(CLOCK_50), .rst_i(iRST), .key_ni(iKEY[1]),
    .pressed_o(unused_lvl2), .press_o(p2)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key3 (
    .clk_i(CLOCK_50), .rst_i(iRST), .key_ni(iKEY[2]),
    .pressed_o(k3_level), .press_o(unused_p3)
  );

  mode_e            mode_q;
  logic             fast_q;
  logic             clk_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_last_d;
  logic             div_hit_d;
`ifdef CLK_STEP_COUNT_EN
  logic [15:0]      step_q;
`endif

  // >= rather than == so a shrinking limit mid-count toggles next cycle.
  always_comb begin
    div_last_d = CNT_W'(fdiv_clamp(iFdiv));
    if (!fast_q) div_last_d = div_last_d << SLOW_SHIFT;
    div_last_d = div_last_d - CNT_W'(1);
    div_hit_d  = (div_q >= div_last_d);
  end

  always_ff @(posedge CLOCK_50 or posedge iRST) begin
    if (iRST) begin
      mode_q <= RST_MODE;
      fast_q <= RST_FAST;
      sel_q  <= RST_SEL;
      clk_q  <= 1'b0;
      div_q  <= '0;
`ifdef CLK_STEP_COUNT_EN
      step_q <= '0;
`endif
    end else begin
      case (mode_q)
        MODE_AUTO: begin
          if (p1) fast_q <= ~fast_q;
          if (p2) begin
            mode_q <= MODE_MANUAL;
            div_q  <= '0;
`ifdef CLK_STEP_COUNT_EN
            step_q <= '0;
`endif
          end else if (div_hit_d) begin
            clk_q <= ~clk_q;
            div_q <= '0;
          end else begin
            div_q <= div_q + CNT_W'(1);
          end
        end
        MODE_MANUAL: begin
          if (p1 && p2) begin
            mode_q <= MODE_AUTO;
            div_q  <= '0;
          end else begin
            if (p1) sel_q[0] <= ~sel_q[0];
            if (p2) sel_q[1] <= ~sel_q[1];
            clk_q <= k3_level;
`ifdef CLK_STEP_COUNT_EN
            if (!clk_q && k3_level) step_q <= step_q + 16'd1;
`endif
          end
        end
        default: mode_q <= RST_MODE;
      endcase
    end
  end

  assign oCLK           = clk_q;
  assign oCLKSelectFast = fast_q;
  assign oCLKSelectAuto = (mode_q == MODE_AUTO);
  assign oSelect        = sel_q;
`ifdef CLK_STEP_COUNT_EN
  assign oStepCount     = step_q;
`endif

endmodule

// File: tb/tb_clk_key_ctrl.sv
// Directed bench for clk_key_ctrl with a small expected-value scoreboard.
// Build with CLK_STEP_COUNT_EN defined to also cover the manual step counter.
module tb_clk_key_ctrl;

  localparam int K1 = 0;
  localparam int K2 = 1;
  localparam int K3 = 2;
  localparam int LIMIT = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iKEY;
  logic [7:0] iFdiv;
  logic       oCLK, oFast, oAuto;
  logic [1:0] oSel;
`ifdef CLK_STEP_COUNT_EN
  logic [15:0] oStep;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  clk_key_ctrl #(.DEBOUNCE_CYCLES(4), .SLOW_SHIFT(2)) dut (
    .CLOCK_50      (clk),
    .iRST          (rst),
    .iKEY          (iKEY),
    .iFdiv         (iFdiv),
    .oCLK          (oCLK),
    .oCLKSelectFast(oFast),
    .oCLKSelectAuto(oAuto),
    .oSelect       (oSel)
`ifdef CLK_STEP_COUNT_EN
    ,
    .oStepCount    (oStep)
`endif
  );

  always #5 clk = ~clk;

  task automatic want(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic got(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Cycles until oCLK next changes; LIMIT on timeout.
  task automatic half(output int c);
    logic p;
    p = oCLK;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (oCLK === p && c < LIMIT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iKEY = 3'b111; iFdiv = 8'd3;
    tick(3);
    want("rst_clk", 0);  got(oCLK);
    want("rst_fast", 1); got(oFast);
    want("rst_auto", 1); got(oAuto);
    want("rst_sel", 0);  got(oSel);
    rst = 1'b0;

    // fast divider, iFdiv=3
    want("fast_first", 3); half(n); got(n);
    want("fast_half", 3);  half(n); got(n);
    want("fast_half2", 3); half(n); got(n);

    // glitchy KEY1 -> one pulse 6 cycles after final low
    iKEY[K1] = 1'b0; tick(2);
    iKEY[K1] = 1'b1; tick(1);
    iKEY[K1] = 1'b0;
    want("p1_not_yet", 1); tick(6); got(oFast);
    want("p1_fast0", 0);   tick(1); got(oFast);
    half(n);
    want("slow_half", 12);  half(n); got(n);
    want("slow_half2", 12); half(n); got(n);
    iKEY[K1] = 1'b1; tick(10);
    want("release_no_pulse", 0); got(oFast);

    // back to fast, then iFdiv 200 -> 2 mid-count, then 0
    iKEY[K1] = 1'b0; tick(7);
    want("p1_fast1", 1); got(oFast);
    iKEY[K1] = 1'b1; tick(7);
    iFdiv = 8'd200;
    half(n);
    tick(150);
    iFdiv = 8'd2;
    want("shrink_next", 1); half(n); got(n);
    want("fdiv2_half", 2);  half(n); got(n);
    want("fdiv2_half2", 2); half(n); got(n);
    iFdiv = 8'd0;
    want("fdiv0_half", 1);  half(n); got(n);
    want("fdiv0_half2", 1); half(n); got(n);

    // enter manual, KEY3 drives oCLK
    iFdiv = 8'd3;
    iKEY[K2] = 1'b0;
    want("p2_pending", 1); tick(6); got(oAuto);
    want("p2_manual", 0);  tick(1); got(oAuto);
    iKEY[K2] = 1'b1;
    want("man_clk_low", 0); tick(3); got(oCLK);
    tick(5);
    iKEY[K3] = 1'b0;
    want("k3_pre", 0);   tick(6); got(oCLK);
    want("k3_press", 1); tick(1); got(oCLK);
    iKEY[K3] = 1'b1;
    want("k3_hold", 1);    tick(6); got(oCLK);
    want("k3_release", 0); tick(1); got(oCLK);
    iKEY[K1] = 1'b0; tick(7);
    want("sel_01", 1); got(oSel);
    iKEY[K1] = 1'b1; tick(7);
    iKEY[K2] = 1'b0; tick(7);
    want("sel_11", 3);     got(oSel);
    want("still_man", 0);  got(oAuto);
    iKEY[K2] = 1'b1; tick(7);

    // p1&p2 together in manual -> back to auto
    iKEY[K2:K1] = 2'b00;
    want("both_pending", 0); tick(6); got(oAuto);
    want("both_auto", 1);    tick(1); got(oAuto);
    want("both_sel", 3);     got(oSel);
    want("both_clk", 0);     got(oCLK);
    want("restart_half", 3); half(n); got(n);
    want("restart_half2", 3); half(n); got(n);
    iKEY = 3'b111; tick(7);

    // async reset mid-count with keys held
    iKEY[K1] = 1'b0; iKEY[K3] = 1'b0; tick(7);
    want("pre_rst_fast", 0); got(oFast);
    if (oCLK === 1'b0) half(n);
    #2 rst = 1'b1;
    #1;
    want("arst_clk", 0);  got(oCLK);
    want("arst_fast", 1); got(oFast);
    want("arst_auto", 1); got(oAuto);
    want("arst_sel", 0);  got(oSel);
    @(negedge clk); rst = 1'b0;
    tick(12);
    want("held_no_pulse", 1); got(oFast);
    iKEY[K1] = 1'b1; tick(7);
    iKEY[K1] = 1'b0; tick(7);
    want("repress_pulse", 0); got(oFast);
    iKEY = 3'b111; tick(7);

`ifdef CLK_STEP_COUNT_EN
    iKEY[K2] = 1'b0; tick(7);
    iKEY[K2] = 1'b1; tick(7);
    for (int i = 0; i < 5; i++) begin
      iKEY[K3] = 1'b0; tick(8);
      iKEY[K3] = 1'b1; tick(8);
    end
    want("step5", 5); got(oStep);
    iKEY[K2:K1] = 2'b00; tick(7);
    iKEY = 3'b111; tick(7);
    iKEY[K2] = 1'b0; tick(7);
    want("step_reentry_auto", 0); got(oAuto);
    want("step_cleared", 0);      got(oStep);
    iKEY = 3'b111; tick(7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
